// File: rtl/inverse_sched_pkg.sv
// inverse_sched_pkg: shared types and default schedule points for the inverse frame scheduler
package inverse_sched_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {PH_CHOL, PH_LTINV, PH_MULT, PH_FINAL} phase_t;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_MAX = 229;
  localparam int DEF_MM_RST_0 = 28;
  localparam int DEF_MM_RST_1 = 98;
  localparam int DEF_MM_RST_2 = 214;
  localparam int DEF_MODE_LO = 89;
  localparam int DEF_MODE_HI = 98;
endpackage

// File: rtl/inverse_sched_if.sv
// inverse_sched_if: host handshake plus mat_mult/array_mult control bundle of the frame scheduler
// master: drives en/start/abort, observes the schedule outputs; slave: the scheduler itself
interface inverse_sched_if #(
  parameter int CNT_W = 8
);
  logic en;
  logic start;
  logic abort;
  logic [CNT_W-1:0] count;
  logic [1:0] phase;
  logic busy;
  logic done;
  logic mat_mult_rst;
  logic mat_mult_mode;
  logic array_mult_rst;
  modport master (
    output en, start, abort,
    input count, phase, busy, done, mat_mult_rst, mat_mult_mode, array_mult_rst
  );
  modport slave (
    input en, start, abort,
    output count, phase, busy, done, mat_mult_rst, mat_mult_mode, array_mult_rst
  );
endinterface

// File: rtl/inverse_sched.sv
// inverse_sched: runs one MAX-cycle frame per start, sequencing mat_mult resets/mode and array_mult reset
// clk, rst_n (asynchronous, active-low)
// bus.en/start/abort in; bus.count, phase, busy, done, mat_mult_rst, mat_mult_mode, array_mult_rst out
module inverse_sched
  import inverse_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int MAX = DEF_MAX,
  parameter int MM_RST_0 = DEF_MM_RST_0,
  parameter int MM_RST_1 = DEF_MM_RST_1,
  parameter int MM_RST_2 = DEF_MM_RST_2,
  parameter int MODE_LO = DEF_MODE_LO,
  parameter int MODE_HI = DEF_MODE_HI
) (
  input logic clk,
  input logic rst_n,
  inverse_sched_if.slave bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic done_q, done_n, mmr_q, mmr_n, hit, last;
  phase_t ph;
  if (MAX < 1 || MAX > (1 << CNT_W)) begin : g_max_chk
    $error("inverse_sched: MAX must be in 1..2**CNT_W");
  end
  assign hit = cnt == CNT_W'(MM_RST_0) || cnt == CNT_W'(MM_RST_1) || cnt == CNT_W'(MM_RST_2);
  assign last = cnt == CNT_W'(MAX - 1);
  // abort wins over everything; en gates all RUN progress including the reset-pulse match
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = 1'b0;
    mmr_n = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      state_n = bus.start && bus.en ? RUN : IDLE;
    end else if (bus.en) begin
      mmr_n = hit;
      done_n = last;
      cnt_n = last ? '0 : cnt + 1'b1;
      state_n = last && !bus.start ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      mmr_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done_q <= done_n;
      mmr_q <= mmr_n;
    end
  assign ph = cnt <= CNT_W'(MM_RST_0) ? PH_CHOL :
              cnt <= CNT_W'(MM_RST_1) ? PH_LTINV :
              cnt <= CNT_W'(MM_RST_2) ? PH_MULT : PH_FINAL;
  assign bus.count = cnt;
  assign bus.phase = ph;
  assign bus.busy = state == RUN;
  assign bus.done = done_q;
  assign bus.mat_mult_rst = mmr_q;
  assign bus.mat_mult_mode = !(cnt >= CNT_W'(MODE_LO) && cnt < CNT_W'(MODE_HI));
  assign bus.array_mult_rst = state != RUN;
endmodule

// File: tb/tb_inverse_sched.sv
// tb_inverse_sched: directed scoreboard bench for inverse_sched
module tb_inverse_sched;
  typedef struct {
    logic [7:0] cnt;
    logic [1:0] ph;
    logic busy, done, mmr, mode, amr;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  logic m_run = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic m_done = 1'b0;
  logic m_mmr = 1'b0;
  int pulses, mode0, dones, busy_low;
  always #5 clk = ~clk;
  inverse_sched_if #(.CNT_W(8)) bus ();
  inverse_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t expect_now();
    exp_t e;
    e.cnt = m_cnt;
    e.ph = m_cnt <= 8'd28 ? 2'd0 : m_cnt <= 8'd98 ? 2'd1 : m_cnt <= 8'd214 ? 2'd2 : 2'd3;
    e.busy = m_run;
    e.done = m_done;
    e.mmr = m_mmr;
    e.mode = !(m_cnt >= 8'd89 && m_cnt <= 8'd97);
    e.amr = !m_run;
    return e;
  endfunction
  task automatic cmp();
    exp_t e;
    e = q.pop_front();
    chk("count", bus.count, e.cnt);
    chk("phase", 8'(bus.phase), 8'(e.ph));
    chk("busy", 8'(bus.busy), 8'(e.busy));
    chk("done", 8'(bus.done), 8'(e.done));
    chk("mat_mult_rst", 8'(bus.mat_mult_rst), 8'(e.mmr));
    chk("mat_mult_mode", 8'(bus.mat_mult_mode), 8'(e.mode));
    chk("array_mult_rst", 8'(bus.array_mult_rst), 8'(e.amr));
  endtask
  // one clock: drive inputs, advance the reference, push its prediction, compare after the edge
  task automatic step(input logic e, input logic s, input logic a);
    logic nd, nm;
    bus.en = e;
    bus.start = s;
    bus.abort = a;
    nd = 1'b0;
    nm = 1'b0;
    if (a) begin
      m_run = 1'b0;
      m_cnt = 8'd0;
    end else if (!m_run) begin
      m_run = s && e;
    end else if (e) begin
      nm = m_cnt == 8'd28 || m_cnt == 8'd98 || m_cnt == 8'd214;
      if (m_cnt == 8'd228) begin
        nd = 1'b1;
        m_cnt = 8'd0;
        m_run = s;
      end else m_cnt = m_cnt + 8'd1;
    end
    m_done = nd;
    m_mmr = nm;
    q.push_back(expect_now());
    @(posedge clk);
    #1;
    cmp();
    pulses += int'(bus.mat_mult_rst);
    mode0 += int'(!bus.mat_mult_mode);
    dones += int'(bus.done);
    busy_low += int'(!bus.busy);
  endtask
  task automatic clear_stats();
    pulses = 0;
    mode0 = 0;
    dones = 0;
    busy_low = 0;
  endtask
  initial begin
    int flen;
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back(expect_now());
    cmp();
    chk("rst_array_mult_rst", 8'(bus.array_mult_rst), 8'd1);
    // 1/2: start at cycle 5, full frame with pulse and mode tracking
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("entry_count", bus.count, 8'd0);
    clear_stats();
    for (int i = 0; i < 228; i++) step(1'b1, 1'b0, 1'b0);
    chk("count_228", bus.count, 8'd228);
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_done", 8'(bus.done), 8'd1);
    chk("wrap_idle", 8'(bus.busy), 8'd0);
    chk("frame_pulses", 8'(pulses), 8'd3);
    chk("frame_mode0", 8'(mode0), 8'd9);
    step(1'b1, 1'b0, 1'b0);
    chk("done_one_cycle", 8'(bus.done), 8'd0);
    // 3: stall four cycles at count 28
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b0);
    clear_stats();
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("stall_count", bus.count, 8'd28);
    chk("stall_no_pulse", 8'(pulses), 8'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("stall_pulse", 8'(bus.mat_mult_rst), 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("stall_pulse_once", 8'(pulses), 8'd1);
    // 5: abort together with start at count 100
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_abort_count", bus.count, 8'd100);
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    chk("abort_count", bus.count, 8'd0);
    chk("abort_idle", 8'(bus.busy), 8'd0);
    chk("abort_amr", 8'(bus.array_mult_rst), 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("abort_no_done", 8'(dones), 8'd0);
    chk("abort_start_ignored", 8'(bus.busy), 8'd0);
    // abort while stalled
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("stalled_abort_idle", 8'(bus.busy), 8'd0);
    // 4: back-to-back frames
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 228; i++) step(1'b1, 1'b0, 1'b0);
    clear_stats();
    step(1'b1, 1'b1, 1'b0);
    chk("b2b_done", 8'(bus.done), 8'd1);
    chk("b2b_busy", 8'(bus.busy), 8'd1);
    chk("b2b_count", bus.count, 8'd0);
    flen = 0;
    dones = 0;
    while (dones == 0 && flen < 300) begin
      step(1'b1, 1'b0, 1'b0);
      flen++;
    end
    chk("b2b_frame_len", 8'(flen), 8'd229);
    chk("b2b_busy_gapless", 8'(busy_low), 8'd1);
    // 6: asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 8'd0);
    chk("arst_busy", 8'(bus.busy), 8'd0);
    chk("arst_done", 8'(bus.done), 8'd0);
    chk("arst_mmr", 8'(bus.mat_mult_rst), 8'd0);
    chk("arst_amr", 8'(bus.array_mult_rst), 8'd1);
    m_run = 1'b0;
    m_cnt = 8'd0;
    m_done = 1'b0;
    m_mmr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
